// File: rtl/mem_access_initiator.sv
// MEM-stage initiator: translates byte addresses, runs a req/ack
// handshake with data memory and stalls the pipeline until done.
module mem_access_initiator #(
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       val_rm,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    output logic              freeze,
    output logic [31:0]       res_data,
    output logic              addr_err,
    output logic              timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      data_q;
    logic             rd_ok;

    logic        acc;
    logic [31:0] off;
    logic        legal;

    assign acc   = mem_r_en | mem_w_en;
    assign off   = alu_res - BASE;
    assign legal = (off < LIMIT) && (off[1:0] == 2'b00);

    // Stall while an access is being accepted or is outstanding
    assign freeze = ((state == IDLE) && acc) || (state == REQ);

    // Load data is presented only in the completion cycle of a clean read
    assign res_data = ((state == DONE) && rd_ok) ? data_q : 32'd0;

    // Access sequencer with registered request and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            data_q    <= '0;
            rd_ok     <= 1'b0;
            addr_err  <= 1'b0;
            timeout   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            addr_err <= 1'b0;
            timeout  <= 1'b0;
            unique case (state)
                IDLE: begin
                    rd_ok <= 1'b0;
                    if (acc && legal) begin
                        mem_addr  <= off[ADDR_W+1:2];
                        mem_wdata <= val_rm;
                        mem_we    <= mem_w_en;
                        mem_req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= REQ;
                    end else if (acc) begin
                        addr_err <= 1'b1;
                        state    <= DONE;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            data_q <= mem_rdata;
                        end
                        rd_ok   <= !mem_we;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        data_q   <= '0;
                        rd_ok    <= 1'b0;
                        timeout  <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

Memory-stage initiator between the pipeline's MEM stage and a variable-latency data memory port. It accepts one load or store per instruction from the stage signals and translates the byte address into a word index. It runs a request/acknowledge handshake with the memory and freezes the pipeline until the access completes. It returns read data to the write-back path and flags illegal addresses and unresponsive memory.

## Interface
- BASE_ADDR, 1024: byte address mapped to word 0 of data memory.
- DEPTH_WORDS, 64: number of 32-bit words in data memory.
- ADDR_W, 6: word-index width; must satisfy 2^ADDR_W = DEPTH_WORDS.
- TIMEOUT, 15: maximum REQ-state cycles to wait for mem_ack.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_res  in  32  effective byte address from EX stage.
- val_rm  in  32  store data.
- mem_w_en  in  1  store request for the current instruction.
- mem_r_en  in  1  load request for the current instruction.
- freeze  out  1  pipeline stall; combinational.
- res_data  out  32  load result.
- addr_err  out  1  one-cycle pulse on a rejected address.
- timeout  out  1  one-cycle pulse when memory failed to acknowledge.
- mem_req  out  1  request valid to memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  word index; valid while mem_req=1.
- mem_wdata  out  32  write data; valid while mem_req=1.
- mem_ack  in  1  memory completion, sampled while mem_req=1.
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1.

## Operation
- Access request: acc = mem_r_en | mem_w_en.
  - If both enables are high, the access is a write. res_data stays 0.
- Address translation, all 32-bit unsigned:
  - off = alu_res - BASE_ADDR (wraps modulo 2^32).
  - Legal iff off < DEPTH_WORDS*4 and off[1:0] == 0.
  - Word index = off[ADDR_W+1:2].
- IDLE state:
  - acc=1 and address legal: latch index, val_rm and we into request registers, clear wait counter, go to REQ.
  - acc=1 and address illegal: set addr_err for the next cycle only, go to DONE. No memory request is issued.
  - acc=0: stay in IDLE.
- REQ state:
  - mem_req=1. mem_we, mem_addr and mem_wdata are driven from the request registers and stay stable throughout REQ.
  - mem_ack=1: capture mem_rdata into the data register if the access is a read, go to DONE.
  - mem_ack=0: increment the wait counter. When the counter reaches TIMEOUT, pulse timeout, load 0 into the data register, go to DONE.
- DONE state:
  - Lasts exactly one cycle, then goes to IDLE unconditionally.
  - Enables are ignored in DONE, so the same instruction is never reissued.
- freeze:
  - freeze = (IDLE & acc) | REQ.
  - freeze is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- res_data:
  - res_data = data register when in DONE and the completed access was a read with no error.
  - res_data = 0 in every other case.
- mem_ack outside REQ is ignored, including late acks after a timeout.

## Timing
- Reset values: state IDLE, freeze 0 when enables are low, res_data 0, addr_err 0, timeout 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, wait counter 0.
- Reset during REQ: mem_req drops asynchronously and the pending access is discarded. No completion or pulse is generated for it.
- Legal access where mem_ack arrives in the k-th REQ cycle (k ≥ 1):
  - freeze is high for k+1 cycles (the IDLE cycle plus k REQ cycles).
  - DONE follows in the next cycle.
  - Minimum total latency is 3 cycles from acc to the instruction leaving the stage.
- Illegal address:
  - freeze is high for 1 cycle.
  - The next cycle is DONE with addr_err=1 and res_data=0.
- Timeout:
  - freeze is high for TIMEOUT+1 cycles.
  - The next cycle is DONE with timeout=1 and res_data=0.
- Back-to-back accesses: an acc in the cycle after DONE starts a new access from IDLE. There is no idle gap beyond DONE.

## Test plan
- Read: alu_res=1032, mem_r_en=1, ack on the 3rd REQ cycle with mem_rdata=0xDEADBEEF.
  - mem_addr=2, mem_we=0, freeze high 4 cycles.
  - DONE: res_data=0xDEADBEEF, then 0 in the following cycle.
- Write: alu_res=1276, mem_w_en=1, val_rm=0x12345678, ack in the 1st REQ cycle.
  - mem_addr=63, mem_we=1, mem_wdata=0x12345678.
  - freeze high 2 cycles, res_data=0 throughout.
- Illegal addresses: alu_res=1280, then 1020, then 1026.
  - Each gives addr_err=1 in DONE, mem_req never asserted, freeze high 1 cycle.
- Timeout: legal read with mem_ack held 0.
  - mem_req high for exactly 15 cycles, then timeout=1 in DONE with res_data=0.
  - An ack injected one cycle after that DONE has no effect.
- Both enables high, alu_res=1024, val_rm=5.
  - Write issued: mem_we=1, mem_addr=0, mem_wdata=5; res_data=0.
- Reset mid-access: assert rst in the 2nd REQ cycle.
  - mem_req=0 and freeze=0 (enables low) immediately.
  - No DONE occurs, and after rst is released the next read completes normally.
